nx_fifo_rr_sched: RTL and testbench

//  - Round-robin read scheduler for NUM_Q nx_fifo_ctrl instances that share one downstream consumer.
//  - Issues at most one ren per cycle, to one queue.
//  - Sticky bursts: stays on a queue for up to MAX_BURST reads.
//  - Gated by a downstream credit counter.
//  - Sits between the per-queue fifo_ctrl empty flags and the shared read-data mux; grant_id drives the mux select.

---
 rtl/nx_fifo_sched_pkg.sv | 17 +
 rtl/nx_rr_pick.sv | 29 ++
 rtl/nx_fifo_rr_sched.sv | 144 ++++++++++++++
 tb/tb_nx_fifo_rr_sched.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/nx_fifo_sched_pkg.sv
// Shared types and helpers for the nx round-robin read scheduler.
// Id/counter widths are derived here so all nx arbiters agree.
package nx_fifo_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } sched_state_e;

    localparam int STAT_W = 16;

    // clog2 clamped to at least one bit
    function automatic int id_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nx_rr_pick.sv
// Combinational round-robin pick: first requester after 'last', wrapping.
// Reused by other nx arbiters.
module nx_rr_pick
    import nx_fifo_sched_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = id_w(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last,
    output logic           gnt_vld,
    output logic [IDW-1:0] gnt_id
);

    // Scan from the far end so the nearest requester is written last.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        for (int k = N; k >= 1; k--) begin
            int idx;
            idx = (int'(last) + k) % N;
            if (req[idx]) begin
                gnt_vld = 1'b1;
                gnt_id  = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/nx_fifo_rr_sched.sv
// Sticky-burst round-robin read scheduler with downstream credit gating.
// Optional per-queue grant counters: define NX_FIFO_RR_SCHED_STATS_EN.
module nx_fifo_rr_sched
    import nx_fifo_sched_pkg::*;
#(
    parameter int NUM_Q     = 4,
    parameter int MAX_BURST = 4,
    parameter int CREDITS   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        clear,
    input  logic [NUM_Q-1:0]            q_empty,
    input  logic                        credit_return,
    output logic [NUM_Q-1:0]            q_ren,
    output logic                        grant_vld,
    output logic [id_w(NUM_Q)-1:0]      grant_id,
    output logic [id_w(CREDITS+1)-1:0]  credit_cnt,
    output logic                        credit_err,
    output logic [NUM_Q*STAT_W-1:0]     stat_grants
);

    localparam int IDW = id_w(NUM_Q);
    localparam int CW  = id_w(CREDITS + 1);
    localparam int BW  = id_w(MAX_BURST + 1);

    sched_state_e   state_q, state_d;
    logic [IDW-1:0] last_q, last_d;
    logic [IDW-1:0] gid_q, gid_d;
    logic [BW-1:0]  burst_q, burst_d;
    logic [CW-1:0]  cred_q, cred_d;
    logic           err_q, err_d;

    logic           can_go, cont, grant;
    logic           pick_vld;
    logic [IDW-1:0] pick_id, sel_id;

    nx_rr_pick #(
        .N   (NUM_Q),
        .IDW (IDW)
    ) u_pick (
        .req     (~q_empty),
        .last    (last_q),
        .gnt_vld (pick_vld),
        .gnt_id  (pick_id)
    );

    // rst gates ren combinationally so nothing leaks out during reset
    assign can_go = ~rst & enable & ~clear & (cred_q != '0);
    assign cont   = (state_q == BURST) & can_go & ~q_empty[last_q]
                  & (burst_q < BW'(MAX_BURST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= IDW'(NUM_Q - 1);
            burst_q <= '0;
            gid_q   <= '0;
            cred_q  <= CW'(CREDITS);
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            burst_q <= burst_d;
            gid_q   <= gid_d;
            cred_q  <= cred_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        burst_d = burst_q;
        if (clear) begin
            state_d = IDLE;
            last_d  = IDW'(NUM_Q - 1);
            burst_d = '0;
        end else if (enable) begin
            if (grant) begin
                last_d  = sel_id;
                burst_d = cont ? burst_q + BW'(1) : BW'(1);
                state_d = (MAX_BURST > 1) ? BURST : IDLE;
            end else begin
                state_d = IDLE;
                burst_d = '0;
            end
        end
    end

    always_comb begin
        grant  = 1'b0;
        sel_id = last_q;
        q_ren  = '0;
        if (cont) begin
            grant = 1'b1;
        end else if (can_go & pick_vld) begin
            grant  = 1'b1;
            sel_id = pick_id;
        end
        if (grant) q_ren[sel_id] = 1'b1;
    end

    always_comb begin
        gid_d  = grant ? sel_id : gid_q;
        cred_d = cred_q;
        err_d  = err_q;
        if (credit_return & ~grant) begin
            if (cred_q == CW'(CREDITS)) err_d = 1'b1;
            else cred_d = cred_q + CW'(1);
        end else if (grant & ~credit_return) begin
            cred_d = cred_q - CW'(1);
        end
    end

    assign grant_vld  = |q_ren;
    assign grant_id   = gid_q;
    assign credit_cnt = cred_q;
    assign credit_err = err_q;

`ifdef NX_FIFO_RR_SCHED_STATS_EN
    logic [STAT_W-1:0] stat_q [NUM_Q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_Q; i++) stat_q[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < NUM_Q; i++) stat_q[i] <= '0;
        end else if (grant && (stat_q[sel_id] != '1)) begin
            stat_q[sel_id] <= stat_q[sel_id] + STAT_W'(1);
        end
    end

    always_comb begin
        stat_grants = '0;
        for (int i = 0; i < NUM_Q; i++)
            stat_grants[i*STAT_W +: STAT_W] = stat_q[i];
    end
`else
    assign stat_grants = '0;
`endif

endmodule

// File: tb/tb_nx_fifo_rr_sched.sv
// Directed self-checking bench for nx_fifo_rr_sched (NUM_Q=4, MAX_BURST=4, CREDITS=8).
module tb_nx_fifo_rr_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        clear;
    logic [3:0]  q_empty;
    logic        credit_return;
    logic [3:0]  q_ren;
    logic        grant_vld;
    logic [1:0]  grant_id;
    logic [3:0]  credit_cnt;
    logic        credit_err;
    logic [63:0] stat_grants;

    int checks = 0;
    int fails  = 0;

    nx_fifo_rr_sched #(
        .NUM_Q     (4),
        .MAX_BURST (4),
        .CREDITS   (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .clear         (clear),
        .q_empty       (q_empty),
        .credit_return (credit_return),
        .q_ren         (q_ren),
        .grant_vld     (grant_vld),
        .grant_id      (grant_id),
        .credit_cnt    (credit_cnt),
        .credit_err    (credit_err),
        .stat_grants   (stat_grants)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] SEQ1 = 32'h0000_1111;
    logic [63:0] st_exp;

    initial begin
        rst = 1'b1;
        enable = 1'b1;
        clear = 1'b0;
        q_empty = 4'b0000;
        credit_return = 1'b0;
        #1;
        chk("rst_ren", q_ren, 0);
        chk("rst_vld", grant_vld, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_cred", credit_cnt, 8);
        chk("rst_err", credit_err, 0);
        chk("rst_stat", stat_grants, 0);
        tick();
        rst = 1'b0;
        #1;

        // 1: all queues full, grants 0,0,0,0,1,1,1,1 then credits exhausted
        for (int i = 0; i < 8; i++) begin
            logic [1:0] e;
            e = (i < 4) ? 2'd0 : 2'd1;
            chk("t1_ren", q_ren, 64'(4'b0001 << e));
            chk("t1_vld", grant_vld, 1);
            tick();
            chk("t1_gid", grant_id, e);
            chk("t1_cred", credit_cnt, 64'(7 - i));
            #1;
        end
        chk("t1_ren_stop", q_ren, 0);
        tick();
        tick();
        chk("t1_cred0", credit_cnt, 0);
        chk("t1_ren_idle", q_ren, 0);

        // 4: same-cycle return at zero credits does not grant
        credit_return = 1'b1;
        #1;
        chk("t4_noren", q_ren, 0);
        tick();
        chk("t4_cred1", credit_cnt, 1);
        credit_return = 1'b0;
        #1;
        chk("t4_ren", q_ren, 4'b0100);
        tick();
        chk("t4_gid", grant_id, 2);
        chk("t4_cred0", credit_cnt, 0);

        // refill credits with every queue empty
        q_empty = 4'b1111;
        credit_return = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("refill", credit_cnt, 8);
        chk("refill_err", credit_err, 0);

        // 2: only q2 non-empty, steady returns, no bubbles across bursts
        q_empty = 4'b1011;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("t2_ren", q_ren, 4'b0100);
            tick();
            chk("t2_gid", grant_id, 2);
            chk("t2_cred", credit_cnt, 8);
        end

        // 5: return at full credits without a grant
        q_empty = 4'b1111;
        tick();
        chk("t5_cred", credit_cnt, 8);
        chk("t5_err", credit_err, 1);
        credit_return = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        chk("t5_err_sticky", credit_err, 1);
        chk("t5_cred_keep", credit_cnt, 8);

        // 3: q1 burst, q1 drains after two reads, q3 taken with no bubble
        q_empty = 4'b1101;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("t3_q1", q_ren, 4'b0010);
            tick();
        end
        q_empty = 4'b0111;
        #1;
        chk("t3_q3", q_ren, 4'b1000);
        tick();
        chk("t3_gid", grant_id, 3);
        chk("t3_cred", credit_cnt, 5);

        // 6a: async reset mid-burst on q2
        q_empty = 4'b1011;
        #1;
        chk("t6_q2", q_ren, 4'b0100);
        tick();
        chk("t6_cred4", credit_cnt, 4);
        rst = 1'b1;
        #1;
        chk("t6_rst_ren", q_ren, 0);
        chk("t6_rst_cred", credit_cnt, 8);
        chk("t6_rst_err", credit_err, 0);
        chk("t6_rst_gid", grant_id, 0);
        rst = 1'b0;
        q_empty = 4'b0000;
        #1;
        chk("t6_q0_first", q_ren, 4'b0001);
        tick();
        #1;
        chk("t6_q0_burst", q_ren, 4'b0001);
        tick();
        chk("t6_cred6", credit_cnt, 6);
`ifdef NX_FIFO_RR_SCHED_STATS_EN
        st_exp = 64'd2;
`else
        st_exp = 64'd0;
`endif
        chk("t6_stat", stat_grants, st_exp);

        // 6b: clear mid-burst keeps credits, restarts at q0
        clear = 1'b1;
        #1;
        chk("t6_clr_ren", q_ren, 0);
        tick();
        chk("t6_clr_cred", credit_cnt, 6);
        chk("t6_clr_stat", stat_grants, 0);
        clear = 1'b0;
        q_empty = 4'b1100;
        #1;
        chk("t6_clr_q0", q_ren, 4'b0001);
        tick();

        // enable low holds the burst; resumes on q0
        enable = 1'b0;
        #1;
        chk("en0_ren", q_ren, 0);
        tick();
        chk("en0_cred", credit_cnt, 5);
        enable = 1'b1;
        #1;
        chk("en1_resume", q_ren, 4'b0001);
        tick();
        chk("en1_gid", grant_id, 0);
        chk("en1_cred", credit_cnt, 4);
        chk("seq1_const", 64'(SEQ1[3:0]), 64'(4'b0001));

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
